serial_code_checker: RTL and testbench
======================================

Name: serial_code_checker

Overview:
- Serial product-code validator for the DE1_SoC lab designs.
- Accepts NUM_DIGITS decimal digits one per handshake, MSB first. Computes a mod-10 checksum using either Luhn or UPC-A weighting.
- Reports code validity plus discount/stolen flags. The flags derive from the product class encoded in the first digit and a "marked" input.
- Sits between the switch/key input conditioning and the LEDR/HEX display logic.

Parameters:
- NUM_DIGITS, 12, total digits per code including the trailing check digit; legal range 2..31.
- CNT_W, $clog2(NUM_DIGITS+1), width of the internal digit counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new code and samples mode and marked.
- mode  input  1  0 = Luhn (doubling), 1 = UPC-A (weight 3/1).
- marked  input  1  item carries a valid purchase mark.
- digit_valid  input  1  digit present this cycle.
- digit  input  4  BCD digit.
- digit_ready  output  1  checker accepts a digit this cycle.
- busy  output  1  code in progress.
- done  output  1  result valid; held until the next start.
- code_ok  output  1  checksum correct and no illegal digit.
- bad_digit  output  1  a digit > 9 was received in this code.
- discount  output  1  discount applies.
- stolen  output  1  stolen alarm.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; accumulator, counter, class bits, sampled mode and sampled marked cleared.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - digit_ready=0; digit_valid is ignored.
  - start -> ACCUM. On the same edge: accumulator=0, count=0, bad_digit=0, sample mode and marked.
- ACCUM:
  - busy=1, digit_ready=1.
  - A digit is accepted on a clock edge where digit_valid=1.
  - Digit index i = count value at acceptance, starting at 0.
  - Weighted position: (NUM_DIGITS-1-i) odd.
  - Luhn, weighted: term = 2d, minus 9 if 2d > 9. Luhn, unweighted: term = d.
  - UPC, weighted: term = 3d mod 10. UPC, unweighted: term = d.
  - Accumulator is kept mod 10 in 4 bits: acc = (acc + term) mod 10. It never exceeds 9.
  - d > 9: set the sticky bad_digit; term = 0; count still advances.
  - At i = 0, latch class bits U=digit[2], P=digit[1], C=digit[0].
  - On acceptance of index NUM_DIGITS-1 -> DONE. Results are registered on that same edge, so done=1 on the cycle after the last accepted digit (latency 1).
  - start while in ACCUM aborts and restarts: same clearing as in IDLE; the partial code is discarded. start has priority over a simultaneous digit_valid.
- DONE:
  - done=1, digit_ready=0, busy=0; outputs are held.
  - code_ok = (acc==0) & ~bad_digit.
  - expensive = (U&C) | (~U&~P&~C).
  - discount = code_ok & ((~U&~P) | (U&P&~C)).
  - stolen = code_ok & expensive & ~marked.
  - start -> ACCUM, with done, code_ok, discount and stolen cleared on that edge.
- Invalid code: discount=0 and stolen=0 regardless of class.
- reset_n asserted mid-code: immediate return to the reset state; no result is produced.
- Changes to mode or marked after start have no effect on the current code.

Decomposition:
- Shared package code_check_pkg:
  - state enum (IDLE, ACCUM, DONE).
  - MODE_LUHN=1'b0, MODE_UPC=1'b1.
  - MAX_DIGIT=4'd9.
- One sub-module, digit_weight:
  - Combinational.
  - Inputs: digit, weighted, mode.
  - Output: 4-bit term.
  - Instantiated once in the checker.

Test Plan:
1. UPC, NUM_DIGITS=12, mode=1, marked=0, digits 0,3,6,0,0,0,2,9,1,4,5,2 -> weighted sum 60; one cycle after the 12th digit: done=1, code_ok=1, discount=1, stolen=1. Repeat with marked=1 -> stolen=0, discount=1.
2. Same code with last digit 3 -> code_ok=0, discount=0, stolen=0, bad_digit=0.
3. Luhn, NUM_DIGITS=11, mode=0, digits 7,9,9,2,7,3,9,8,7,1,3 -> code_ok=1. First digit 7 gives U=P=C=1 -> discount=0, expensive=1, stolen=~marked. Last digit 0 -> code_ok=0.
4. UPC valid code with digit 4'hB injected at index 5 -> bad_digit=1, code_ok=0; done still asserts after exactly 12 accepted digits.
5. start pulse after 6 digits, then a full valid UPC code -> result matches scenario 1. start coincident with digit_valid -> that digit is not counted.
6. reset_n low for one cycle at digit 8 -> all outputs 0 immediately and state IDLE; digit_valid pulses are ignored until start; a subsequent full code gives the correct result. Also check digit_valid gaps (idle cycles between digits) do not change the result.

Source files
------------

// File: rtl/serial_code_checker_pkg.sv
// Shared types and constants for the serial product-code checker.
// Mod-10 helper keeps the running checksum in 4 bits.
package code_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic       MODE_LUHN = 1'b0;
  localparam logic       MODE_UPC  = 1'b1;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  function automatic logic [3:0] add_mod10(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 5'd9) ? 4'(s - 5'd10) : s[3:0];
  endfunction

endpackage

// File: rtl/serial_code_checker_if.sv
// Digit stream and result bundle between input conditioning,
// the code checker and the display logic.
interface serial_code_checker_if;

  logic       start;
  logic       mode;
  logic       marked;
  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic       busy;
  logic       done;
  logic       code_ok;
  logic       bad_digit;
  logic       discount;
  logic       stolen;

  modport master (
    output start, mode, marked,
    output digit_valid, digit,
    input  digit_ready, busy, done,
    input  code_ok, bad_digit,
    input  discount, stolen
  );

  modport slave (
    input  start, mode, marked,
    input  digit_valid, digit,
    output digit_ready, busy, done,
    output code_ok, bad_digit,
    output discount, stolen
  );

endinterface

// File: rtl/serial_code_checker_digit_weight.sv
// Per-digit checksum term: Luhn doubling or UPC-A triple weight,
// reduced to a single decimal digit.
module digit_weight
  import code_check_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_weighted,
  input  logic       i_mode,
  output logic [3:0] o_term
);

  logic [4:0] w_dbl;
  logic [5:0] w_tri;

  assign w_dbl = {i_digit, 1'b0};
  assign w_tri = {2'b00, i_digit}
               + {1'b0, i_digit, 1'b0};

  always_comb begin
    o_term = i_digit;
    unique case (1'b1)
      !i_weighted:
        o_term = i_digit;
      i_weighted && (i_mode == MODE_LUHN):
        o_term = (w_dbl > 5'd9) ?
                 4'(w_dbl - 5'd9) : w_dbl[3:0];
      i_weighted && (i_mode == MODE_UPC):
        o_term = (w_tri > 6'd19) ? 4'(w_tri - 6'd20) :
                 (w_tri > 6'd9)  ? 4'(w_tri - 6'd10) :
                 w_tri[3:0];
    endcase
  end

endmodule

// File: rtl/serial_code_checker.sv
// Serial product-code validator: accumulates a mod-10 checksum
// over NUM_DIGITS digits and derives discount/stolen flags.
module serial_code_checker
  import code_check_pkg::*;
#(
  parameter int NUM_DIGITS = 12,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input logic                  clk,
  input logic                  reset_n,
  serial_code_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_u, r_p, r_c;
  logic             r_mode, r_marked;
  logic             r_bad, r_done, r_ok;
  logic             r_disc, r_stol;

  logic             w_accept, w_last;
  logic [CNT_W-1:0] w_pos;
  logic             w_weighted, w_bad_d;
  logic [3:0]       w_term, w_acc_nxt;
  logic             w_ok, w_exp, w_disc, w_stol;
  logic             w_busy, w_ready;

  // start wins over a digit presented in the same cycle
  assign w_accept   = (r_state == ACCUM)
                    & bus.digit_valid & ~bus.start;
  assign w_last     = w_accept & (r_cnt == LAST);
  assign w_pos      = LAST - r_cnt;
  assign w_weighted = w_pos[0];
  assign w_bad_d    = bus.digit > MAX_DIGIT;

  digit_weight u_weight (
    .i_digit    (bus.digit),
    .i_weighted (w_weighted),
    .i_mode     (r_mode),
    .o_term     (w_term)
  );

  assign w_acc_nxt = add_mod10(r_acc,
                     w_bad_d ? 4'd0 : w_term);
  assign w_ok   = (w_acc_nxt == 4'd0) & ~(r_bad | w_bad_d);
  assign w_exp  = (r_u & r_c) | (~r_u & ~r_p & ~r_c);
  assign w_disc = w_ok & ((~r_u & ~r_p)
                | (r_u & r_p & ~r_c));
  assign w_stol = w_ok & w_exp & ~r_marked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (bus.start) w_next = ACCUM;
      ACCUM: begin
        if (bus.start)   w_next = ACCUM;
        else if (w_last) w_next = DONE;
      end
      DONE:  if (bus.start) w_next = ACCUM;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_ready = 1'b0;
    if (r_state == ACCUM) begin
      w_busy  = 1'b1;
      w_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_u      <= 1'b0;
      r_p      <= 1'b0;
      r_c      <= 1'b0;
      r_mode   <= 1'b0;
      r_marked <= 1'b0;
      r_bad    <= 1'b0;
      r_done   <= 1'b0;
      r_ok     <= 1'b0;
      r_disc   <= 1'b0;
      r_stol   <= 1'b0;
    end else if (bus.start) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mode   <= bus.mode;
      r_marked <= bus.marked;
      r_bad    <= 1'b0;
      r_done   <= 1'b0;
      r_ok     <= 1'b0;
      r_disc   <= 1'b0;
      r_stol   <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_bad_d) r_bad <= 1'b1;
      if (r_cnt == '0) begin
        r_u <= bus.digit[2];
        r_p <= bus.digit[1];
        r_c <= bus.digit[0];
      end
      if (w_last) begin
        r_done <= 1'b1;
        r_ok   <= w_ok;
        r_disc <= w_disc;
        r_stol <= w_stol;
      end
    end
  end

  assign bus.digit_ready = w_ready;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.code_ok     = r_ok;
  assign bus.bad_digit   = r_bad;
  assign bus.discount    = r_disc;
  assign bus.stolen      = r_stol;

endmodule

// File: tb/tb_serial_code_checker.sv
// Bench for serial_code_checker: 12-digit and 11-digit instances
// fed the same stream, results scored against expected records.
module tb_serial_code_checker;
  import code_check_pkg::*;

  typedef struct packed {
    logic        mode;
    logic        marked;
    logic [4:0]  n;
    logic [47:0] code;
    logic        ok;
    logic        bad;
    logic        disc;
    logic        stol;
  } vec_t;

  typedef struct packed {
    logic ok;
    logic bad;
    logic disc;
    logic stol;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t q12[$];
  exp_t q11[$];
  vec_t tbl[10];

  serial_code_checker_if bus12();
  serial_code_checker_if bus11();

  assign bus11.start       = bus12.start;
  assign bus11.mode        = bus12.mode;
  assign bus11.marked      = bus12.marked;
  assign bus11.digit_valid = bus12.digit_valid;
  assign bus11.digit       = bus12.digit;

  serial_code_checker #(.NUM_DIGITS(12)) u_dut12 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus12.slave)
  );

  serial_code_checker #(.NUM_DIGITS(11)) u_dut11 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus11.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [6:0] outs12();
    return {bus12.digit_ready, bus12.busy,
            bus12.done, bus12.code_ok,
            bus12.bad_digit, bus12.discount,
            bus12.stolen};
  endfunction

  function automatic logic [6:0] outs11();
    return {bus11.digit_ready, bus11.busy,
            bus11.done, bus11.code_ok,
            bus11.bad_digit, bus11.discount,
            bus11.stolen};
  endfunction

  // scoreboard: pop one record on each rising done
  initial begin : mon
    logic p12, p11;
    exp_t e;
    p12 = 1'b0;
    p11 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus12.done && !p12) begin
        if (q12.size() == 0) begin
          chk("dut12.unexpected_done", 8'd1, 8'd0);
        end else begin
          e = q12.pop_front();
          chk("dut12.code_ok", 8'(bus12.code_ok), 8'(e.ok));
          chk("dut12.bad_digit", 8'(bus12.bad_digit),
              8'(e.bad));
          chk("dut12.discount", 8'(bus12.discount),
              8'(e.disc));
          chk("dut12.stolen", 8'(bus12.stolen), 8'(e.stol));
        end
      end
      if (bus11.done && !p11 && q11.size() != 0) begin
        e = q11.pop_front();
        chk("dut11.code_ok", 8'(bus11.code_ok), 8'(e.ok));
        chk("dut11.bad_digit", 8'(bus11.bad_digit),
            8'(e.bad));
        chk("dut11.discount", 8'(bus11.discount),
            8'(e.disc));
        chk("dut11.stolen", 8'(bus11.stolen), 8'(e.stol));
      end
      p12 = bus12.done;
      p11 = bus11.done;
    end
  end

  task automatic run_code(input vec_t v, input int gap,
                          input bit coinc);
    exp_t e;
    e = '{ok: v.ok, bad: v.bad, disc: v.disc, stol: v.stol};
    @(negedge clk);
    bus12.start       = 1'b1;
    bus12.mode        = v.mode;
    bus12.marked      = v.marked;
    bus12.digit_valid = coinc;
    bus12.digit       = 4'd9;
    if (v.n == 5'd12) q12.push_back(e);
    else              q11.push_back(e);
    @(negedge clk);
    bus12.start  = 1'b0;
    bus12.mode   = ~v.mode;
    bus12.marked = ~v.marked;
    for (int i = 0; i < int'(v.n); i++) begin
      bus12.digit_valid = 1'b1;
      bus12.digit       = v.code[47-4*i -: 4];
      @(negedge clk);
      bus12.digit_valid = 1'b0;
      if (i < int'(v.n) - 1) repeat (gap) @(negedge clk);
    end
    if (v.n == 5'd12) begin
      chk("latency12.done", 8'(bus12.done), 8'd1);
      chk("latency12.popped", 8'(q12.size()), 8'd0);
    end else begin
      chk("latency11.done", 8'(bus11.done), 8'd1);
      chk("latency11.popped", 8'(q11.size()), 8'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{1'b1, 1'b0, 5'd12, 48'h036000291452,
               1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 5'd12, 48'h036000291452,
               1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 5'd12, 48'h036000291453,
               1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 5'd12, 48'h03600B291452,
               1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 5'd11, 48'h799273987130,
               1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 5'd11, 48'h799273987130,
               1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 5'd11, 48'h799273987100,
               1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 5'd12, 48'h600000000002,
               1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 5'd12, 48'h400000000008,
               1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 5'd12, 48'h500000000005,
               1'b1, 1'b0, 1'b0, 1'b1};

    reset_n           = 1'b0;
    bus12.start       = 1'b0;
    bus12.mode        = 1'b0;
    bus12.marked      = 1'b0;
    bus12.digit_valid = 1'b0;
    bus12.digit       = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset.outs12", 8'(outs12()), 8'd0);
    chk("reset.outs11", 8'(outs11()), 8'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) run_code(tbl[k], 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("held.done", 8'(bus12.done), 8'd1);
    chk("held.busy", 8'(bus12.busy), 8'd0);
    chk("held.stolen", 8'(bus12.stolen), 8'd1);

    // abort after 6 digits, then restart with a colliding digit
    bus12.start  = 1'b1;
    bus12.mode   = 1'b1;
    bus12.marked = 1'b0;
    @(negedge clk);
    bus12.start = 1'b0;
    chk("accum.busy_ready",
        8'({bus12.busy, bus12.digit_ready}), 8'd3);
    chk("accum.done_cleared", 8'(bus12.done), 8'd0);
    for (int i = 0; i < 6; i++) begin
      bus12.digit_valid = 1'b1;
      bus12.digit       = tbl[0].code[47-4*i -: 4];
      @(negedge clk);
    end
    bus12.digit_valid = 1'b0;
    run_code(tbl[0], 0, 1'b1);

    // reset in the middle of a code
    @(negedge clk);
    bus12.start  = 1'b1;
    bus12.mode   = 1'b1;
    bus12.marked = 1'b0;
    @(negedge clk);
    bus12.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus12.digit_valid = 1'b1;
      bus12.digit       = 4'hC;
      @(negedge clk);
    end
    chk("pre_reset.bad", 8'(bus12.bad_digit), 8'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset.outs12", 8'(outs12()), 8'd0);
    chk("midreset.outs11", 8'(outs11()), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus12.digit_valid = 1'b1;
      bus12.digit       = 4'd5;
      @(negedge clk);
      chk("idle.ignores_digits", 8'(outs12()), 8'd0);
    end
    bus12.digit_valid = 1'b0;
    run_code(tbl[0], 2, 1'b0);
    run_code(tbl[4], 3, 1'b0);

    repeat (3) @(negedge clk);
    chk("end.queue12", 8'(q12.size()), 8'd0);
    chk("end.queue11", 8'(q11.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
